// File: rtl/i2c_apb_master.sv
// APB requester: turns a local valid/ready request into one APB transfer.
// The FSM walks IDLE -> SETUP -> ACCESS. All APB outputs come straight from flops.
//
// Ports
//   PCLK, PRESETn        : clock (rising edge) and async active-low reset
//   req_valid/req_ready  : request handshake; req_ready is high only in IDLE
//   req_write/addr/wdata : request fields, latched on the handshake
//   rsp_valid            : one-cycle pulse when a transfer finishes
//   rsp_rdata            : read data of the last completion (0 for writes and aborts)
//   rsp_err              : last transfer was aborted by timeout
//   PSELx/PENABLE/PWRITE/PADDR/PWDATA : APB request signals
//   PREADY/PRDATA        : APB completer response, sampled only in ACCESS
//
// Optional feature: define APB_TIMEOUT_EN to add the ACCESS-phase timeout
// (TIMEOUT_CYCLES wait cycles, then abort with rsp_err=1).
module i2c_apb_master #(
   parameter int unsigned ADDR_W         = 7,
   parameter int unsigned DATA_W         = 8,
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic              PCLK,
   input  logic              PRESETn,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err,
   output logic              PSELx,
   output logic              PENABLE,
   output logic              PWRITE,
   output logic [ADDR_W-1:0] PADDR,
   output logic [DATA_W-1:0] PWDATA,
   input  logic              PREADY,
   input  logic [DATA_W-1:0] PRDATA
);

   // A zero timeout would abort before any wait cycle could be observed.
   if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be at least 1");
   end

   typedef enum logic [1:0] {StIdle, StSetup, StAccess} state_e;

   state_e              state_q, state_d;
   logic                psel_q, psel_d;
   logic                penable_q, penable_d;
   logic                pwrite_q, pwrite_d;
   logic [ADDR_W-1:0]   paddr_q, paddr_d;
   logic [DATA_W-1:0]   pwdata_q, pwdata_d;
   logic                rsp_valid_q, rsp_valid_d;
   logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;

`ifdef APB_TIMEOUT_EN
   localparam int unsigned CntW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
   localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

   logic [CntW-1:0]     cnt_q, cnt_d;
   logic                rsp_err_q, rsp_err_d;
`endif

   always_comb begin
      state_d     = state_q;
      psel_d      = psel_q;
      penable_d   = penable_q;
      pwrite_d    = pwrite_q;
      paddr_d     = paddr_q;
      pwdata_d    = pwdata_q;
      rsp_valid_d = 1'b0;
      rsp_rdata_d = rsp_rdata_q;
`ifdef APB_TIMEOUT_EN
      cnt_d       = cnt_q;
      rsp_err_d   = rsp_err_q;
`endif
      case (state_q)
         StIdle: begin
            if (req_valid) begin
               state_d   = StSetup;
               psel_d    = 1'b1;
               penable_d = 1'b0;
               pwrite_d  = req_write;
               paddr_d   = req_addr;
               pwdata_d  = req_wdata;
            end
         end
         StSetup: begin
            state_d   = StAccess;
            penable_d = 1'b1;
`ifdef APB_TIMEOUT_EN
            cnt_d     = '0;
`endif
         end
         StAccess: begin
            if (PREADY) begin
               state_d     = StIdle;
               psel_d      = 1'b0;
               penable_d   = 1'b0;
               pwrite_d    = 1'b0;
               paddr_d     = '0;
               pwdata_d    = '0;
               rsp_valid_d = 1'b1;
               rsp_rdata_d = pwrite_q ? '0 : PRDATA;
`ifdef APB_TIMEOUT_EN
               rsp_err_d   = 1'b0;
`endif
            end
`ifdef APB_TIMEOUT_EN
            // This edge completes the TIMEOUT_CYCLES-th consecutive wait cycle.
            else if (cnt_q == CntLast) begin
               state_d     = StIdle;
               psel_d      = 1'b0;
               penable_d   = 1'b0;
               pwrite_d    = 1'b0;
               paddr_d     = '0;
               pwdata_d    = '0;
               rsp_valid_d = 1'b1;
               rsp_rdata_d = '0;
               rsp_err_d   = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
`endif
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         state_q     <= StIdle;
         psel_q      <= 1'b0;
         penable_q   <= 1'b0;
         pwrite_q    <= 1'b0;
         paddr_q     <= '0;
         pwdata_q    <= '0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
`ifdef APB_TIMEOUT_EN
         cnt_q       <= '0;
         rsp_err_q   <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         psel_q      <= psel_d;
         penable_q   <= penable_d;
         pwrite_q    <= pwrite_d;
         paddr_q     <= paddr_d;
         pwdata_q    <= pwdata_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
`ifdef APB_TIMEOUT_EN
         cnt_q       <= cnt_d;
         rsp_err_q   <= rsp_err_d;
`endif
      end
   end

   assign req_ready = (state_q == StIdle);
   assign PSELx     = psel_q;
   assign PENABLE   = penable_q;
   assign PWRITE    = pwrite_q;
   assign PADDR     = paddr_q;
   assign PWDATA    = pwdata_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rsp_rdata_q;
`ifdef APB_TIMEOUT_EN
   assign rsp_err   = rsp_err_q;
`else
   assign rsp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_i2c_apb_master.sv
// Directed bench for i2c_apb_master (default parameters). APB signals are
// compared as one packed bundle {PSELx, PENABLE, PWRITE, PADDR, PWDATA} and the
// response as {rsp_valid, rsp_err, rsp_rdata}, sampled 1 ns after each rising edge.
module tb_i2c_apb_master;

   logic       PCLK;
   logic       PRESETn;
   logic       req_valid;
   logic       req_ready;
   logic       req_write;
   logic [6:0] req_addr;
   logic [7:0] req_wdata;
   logic       rsp_valid;
   logic [7:0] rsp_rdata;
   logic       rsp_err;
   logic       PSELx;
   logic       PENABLE;
   logic       PWRITE;
   logic [6:0] PADDR;
   logic [7:0] PWDATA;
   logic       PREADY;
   logic [7:0] PRDATA;

   int vectors;
   int miscompares;

   logic [17:0] apb_bus;
   logic [9:0]  rsp_bus;
   logic [17:0] exp_apb;
   logic [9:0]  exp_rsp;

   assign apb_bus = {PSELx, PENABLE, PWRITE, PADDR, PWDATA};
   assign rsp_bus = {rsp_valid, rsp_err, rsp_rdata};

   i2c_apb_master #(
      .ADDR_W         (7),
      .DATA_W         (8),
      .TIMEOUT_CYCLES (16)
   ) dut (
      .PCLK      (PCLK),
      .PRESETn   (PRESETn),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_write (req_write),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .rsp_valid (rsp_valid),
      .rsp_rdata (rsp_rdata),
      .rsp_err   (rsp_err),
      .PSELx     (PSELx),
      .PENABLE   (PENABLE),
      .PWRITE    (PWRITE),
      .PADDR     (PADDR),
      .PWDATA    (PWDATA),
      .PREADY    (PREADY),
      .PRDATA    (PRDATA)
   );

   initial PCLK = 1'b0;
   always #5 PCLK = ~PCLK;

   task automatic step();
      @(posedge PCLK);
      #1;
   endtask

   task automatic test_reset();
      PRESETn = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
      req_wdata = '0; PREADY = 1'b0; PRDATA = '0;
      #12;
      vectors++;
      if ({apb_bus, rsp_bus, req_ready} !== {18'h0, 10'h0, 1'b1}) begin
         miscompares++;
         $display("FAIL reset_state got apb=%h rsp=%h rdy=%b want apb=0 rsp=0 rdy=1",
                  apb_bus, rsp_bus, req_ready);
      end
      @(negedge PCLK);
      PRESETn = 1'b1;
      step();
      vectors++;
      if ({apb_bus, rsp_bus, req_ready} !== {18'h0, 10'h0, 1'b1}) begin
         miscompares++;
         $display("FAIL reset_release got apb=%h rsp=%h rdy=%b want apb=0 rsp=0 rdy=1",
                  apb_bus, rsp_bus, req_ready);
      end
   endtask

   // Write 0x2A to 0x15, PREADY tied high; PRDATA junk must not reach rsp_rdata.
   task automatic test_write();
      req_valid = 1'b1; req_write = 1'b1; req_addr = 7'h15; req_wdata = 8'h2A;
      PREADY = 1'b1; PRDATA = 8'hFF;
      step();
      req_valid = 1'b0; req_addr = 7'h7F; req_wdata = 8'h00;
      exp_apb = {1'b1, 1'b0, 1'b1, 7'h15, 8'h2A};
      vectors++;
      if ({apb_bus, req_ready, rsp_valid} !== {exp_apb, 1'b0, 1'b0}) begin
         miscompares++;
         $display("FAIL wr_setup got apb=%h rdy=%b rv=%b want apb=%h rdy=0 rv=0",
                  apb_bus, req_ready, rsp_valid, exp_apb);
      end
      step();
      exp_apb = {1'b1, 1'b1, 1'b1, 7'h15, 8'h2A};
      vectors++;
      if ({apb_bus, rsp_valid} !== {exp_apb, 1'b0}) begin
         miscompares++;
         $display("FAIL wr_access got apb=%h rv=%b want apb=%h rv=0", apb_bus, rsp_valid,
                  exp_apb);
      end
      step();
      exp_rsp = {1'b1, 1'b0, 8'h00};
      vectors++;
      if ({apb_bus, rsp_bus, req_ready} !== {18'h0, exp_rsp, 1'b1}) begin
         miscompares++;
         $display("FAIL wr_done got apb=%h rsp=%h rdy=%b want apb=0 rsp=%h rdy=1",
                  apb_bus, rsp_bus, req_ready, exp_rsp);
      end
      step();
      vectors++;
      if ({apb_bus, rsp_valid} !== {18'h0, 1'b0}) begin
         miscompares++;
         $display("FAIL wr_after got apb=%h rv=%b want apb=0 rv=0", apb_bus, rsp_valid);
      end
   endtask

   // Read 0x03 with three wait cycles, then PREADY with PRDATA=0x5C.
   task automatic test_read_wait();
      req_valid = 1'b1; req_write = 1'b0; req_addr = 7'h03; req_wdata = 8'h99;
      PREADY = 1'b0; PRDATA = 8'hEE;
      step();
      req_valid = 1'b0;
      exp_apb = {1'b1, 1'b0, 1'b0, 7'h03, 8'h99};
      vectors++;
      if (apb_bus !== exp_apb) begin
         miscompares++;
         $display("FAIL rd_setup got apb=%h want %h", apb_bus, exp_apb);
      end
      for (int i = 0; i < 4; i++) begin
         step();
         exp_apb = {1'b1, 1'b1, 1'b0, 7'h03, 8'h99};
         vectors++;
         if ({apb_bus, rsp_valid} !== {exp_apb, 1'b0}) begin
            miscompares++;
            $display("FAIL rd_access%0d got apb=%h rv=%b want apb=%h rv=0", i, apb_bus,
                     rsp_valid, exp_apb);
         end
         if (i == 3) begin
            PREADY = 1'b1; PRDATA = 8'h5C;
         end
      end
      step();
      PREADY = 1'b0; PRDATA = 8'hA5;
      exp_rsp = {1'b1, 1'b0, 8'h5C};
      vectors++;
      if ({apb_bus, rsp_bus} !== {18'h0, exp_rsp}) begin
         miscompares++;
         $display("FAIL rd_done got apb=%h rsp=%h want apb=0 rsp=%h", apb_bus, rsp_bus,
                  exp_rsp);
      end
      step();
      step();
      exp_rsp = {1'b0, 1'b0, 8'h5C};
      vectors++;
      if (rsp_bus !== exp_rsp) begin
         miscompares++;
         $display("FAIL rd_hold got rsp=%h want %h", rsp_bus, exp_rsp);
      end
   endtask

   // Two writes queued behind a continuously high req_valid.
   task automatic test_back_to_back();
      int pulses;
      pulses = 0;
      req_valid = 1'b1; req_write = 1'b1; req_addr = 7'h01; req_wdata = 8'h11;
      PREADY = 1'b1;
      step();
      exp_apb = {1'b1, 1'b0, 1'b1, 7'h01, 8'h11};
      vectors++;
      if (apb_bus !== exp_apb) begin
         miscompares++;
         $display("FAIL b2b_setup1 got apb=%h want %h", apb_bus, exp_apb);
      end
      req_addr = 7'h02; req_wdata = 8'h22;
      step();
      step();
      pulses += int'(rsp_valid);
      vectors++;
      if ({PSELx, req_ready, rsp_valid, rsp_rdata} !== {1'b0, 1'b1, 1'b1, 8'h00}) begin
         miscompares++;
         $display("FAIL b2b_idle1 got sel=%b rdy=%b rv=%b rd=%h want sel=0 rdy=1 rv=1 rd=00",
                  PSELx, req_ready, rsp_valid, rsp_rdata);
      end
      step();
      req_valid = 1'b0;
      exp_apb = {1'b1, 1'b0, 1'b1, 7'h02, 8'h22};
      vectors++;
      if ({apb_bus, rsp_valid} !== {exp_apb, 1'b0}) begin
         miscompares++;
         $display("FAIL b2b_setup2 got apb=%h rv=%b want apb=%h rv=0", apb_bus, rsp_valid,
                  exp_apb);
      end
      step();
      pulses += int'(rsp_valid);
      step();
      pulses += int'(rsp_valid);
      step();
      pulses += int'(rsp_valid);
      vectors++;
      if ({pulses, PSELx} !== {32'd2, 1'b0}) begin
         miscompares++;
         $display("FAIL b2b_pulses got pulses=%0d sel=%b want pulses=2 sel=0", pulses, PSELx);
      end
   endtask

   // Async reset while a write sits in ACCESS: outputs drop before any clock edge.
   task automatic test_reset_mid();
      int seen;
      seen = 0;
      req_valid = 1'b1; req_write = 1'b1; req_addr = 7'h4B; req_wdata = 8'hC3;
      PREADY = 1'b0;
      step();
      req_valid = 1'b0;
      step();
      vectors++;
      if (PENABLE !== 1'b1) begin
         miscompares++;
         $display("FAIL rst_mid_access got penable=%b want 1", PENABLE);
      end
      #2;
      PRESETn = 1'b0;
      #1;
      vectors++;
      if ({apb_bus, rsp_bus, req_ready} !== {18'h0, 10'h0, 1'b1}) begin
         miscompares++;
         $display("FAIL rst_mid_async got apb=%h rsp=%h rdy=%b want apb=0 rsp=0 rdy=1",
                  apb_bus, rsp_bus, req_ready);
      end
      PREADY = 1'b1;
      @(negedge PCLK);
      @(negedge PCLK);
      PRESETn = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         seen += int'(rsp_valid);
         vectors++;
         if ({req_ready, PSELx} !== 2'b10) begin
            miscompares++;
            $display("FAIL rst_mid_after%0d got rdy=%b sel=%b want rdy=1 sel=0", i, req_ready,
                     PSELx);
         end
      end
      vectors++;
      if (seen !== 0) begin
         miscompares++;
         $display("FAIL rst_mid_no_rsp got %0d rsp_valid pulses want 0", seen);
      end
   endtask

`ifdef APB_TIMEOUT_EN
   // expire_ready=1 raises PREADY on the expiry edge, which must win over the abort.
   task automatic test_timeout(input logic expire_ready);
      req_valid = 1'b1; req_write = 1'b0; req_addr = 7'h33; req_wdata = 8'h00;
      PREADY = 1'b0; PRDATA = 8'h6D;
      step();
      req_valid = 1'b0;
      step();
      // 16 ACCESS cycles with PREADY low before the expiry edge.
      for (int i = 0; i < 16; i++) begin
         vectors++;
         if ({PSELx, PENABLE, rsp_valid} !== 3'b110) begin
            miscompares++;
            $display("FAIL to_wait%0d got sel=%b en=%b rv=%b want 1 1 0", i, PSELx, PENABLE,
                     rsp_valid);
         end
         if (i == 15) PREADY = expire_ready;
         step();
      end
      PREADY = 1'b0;
      exp_rsp = expire_ready ? {1'b1, 1'b0, 8'h6D} : {1'b1, 1'b1, 8'h00};
      vectors++;
      if ({PSELx, PENABLE, rsp_bus} !== {2'b00, exp_rsp}) begin
         miscompares++;
         $display("FAIL to_end%0d got sel=%b en=%b rsp=%h want sel=0 en=0 rsp=%h",
                  expire_ready, PSELx, PENABLE, rsp_bus, exp_rsp);
      end
      step();
      vectors++;
      if ({PSELx, rsp_valid} !== 2'b00) begin
         miscompares++;
         $display("FAIL to_after%0d got sel=%b rv=%b want 0 0", expire_ready, PSELx,
                  rsp_valid);
      end
   endtask
`endif

   initial begin
      vectors = 0;
      miscompares = 0;
      test_reset();
      test_write();
      test_read_wait();
`ifdef APB_TIMEOUT_EN
      test_timeout(1'b0);
      test_timeout(1'b1);
`endif
      test_back_to_back();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
